clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable integer clock divider with 50% duty for odd and even ratios.
//  Next generation of the fixed divide-by-7 CPU clock divider; feeds CPUCLK and
//  peripheral clocks from the board clock. Ratio changes are glitch-free, and the
//  divided clock can be started and stopped cleanly.
// PARAMETERS
//  CNT_W        8   width of ratio and period counter; max ratio 2**CNT_W-1
//  DEFAULT_DIV  7   ratio after reset; must be >= 2
// PORTS
//  clk          in   1      source clock; both edges used
//  rst_n        in   1      asynchronous, active-low reset
//  en           in   1      run request for the divided clock
//  div_ratio    in   CNT_W  requested ratio N
//  div_load     in   1      1-cycle strobe; captures div_ratio into the pending slot
//  clk_out      out  1      divided clock, duty 50% (N/2 source periods high)
//  div_cur      out  CNT_W  ratio currently in effect
//  div_err      out  1      sticky flag; set when div_load sees N<2; cleared by reset only
//  clk_out_tick out  1      [CLK_DIV_TICK_EN only] 1-cycle posedge pulse per clk_out rise
// BEHAVIOUR
//  - Reset (rst_n=0, async): cnt=0, pos_q=0, neg_q=0, clk_out=0, div_cur=DEFAULT_DIV,
//    pend_vld=0, div_err=0, running=0, clk_out_tick=0.
//  - Period counter cnt, posedge: counts 0..div_cur-1 and wraps while running.
//    The wrap cycle is cnt==div_cur-1.
//  - pos_q (posedge reg) = running && (cnt < H), where H=N/2 for even N and
//    H=(N-1)/2 for odd N.
//  - neg_q (negedge reg) = pos_q delayed half a source cycle.
//  - clk_out = N even ? pos_q : (pos_q | neg_q). High time is exactly N/2 source periods.
//    The parity select is registered with div_cur, so it changes only at a wrap.
//  - Latency: clk_out first rises 1 posedge after running is set.
//  - div_load with div_ratio>=2: pend=div_ratio, pend_vld=1. A new load before
//    apply overwrites the pending value (last wins).
//  - div_load with div_ratio<2: no pending update; div_err=1.
//  - Apply rule: on the wrap cycle with pend_vld=1:
//    div_cur<=pend, pend_vld<=0, cnt<=0. The new period starts at the next high phase.
//    Never apply mid-period, so no runt pulse.
//  - If the apply happens while stopped, it takes effect immediately.
//  - div_load on the wrap cycle itself: the new value is captured as pending and
//    applies at the following wrap.
//  - Run control FSM, posedge:
//    IDLE (running=0, cnt=0, clk_out=0) -en-> RUN.
//    RUN -!en-> STOP. STOP completes the current period up to the wrap, then -> IDLE.
//    STOP -en before wrap-> RUN; the period continues uninterrupted.
//  - clk_out is low in IDLE and never truncated.
//  - Ratio N=2**CNT_W-1 is legal. The counter compare is unsigned CNT_W wide and never
//    overflows.
//  - Reset asserted mid-period forces clk_out low immediately (async). This is
//    acceptable at reset.
// CONFIGURATION
//  - CLK_DIV_TICK_EN defined: port clk_out_tick exists. It is registered and high for
//    one clk cycle on the posedge where cnt==0 and running, aligned with the clk_out rise.
//  - CLK_DIV_TICK_EN undefined: port and logic are absent. All other behaviour is
//    identical.
// STRUCTURE
//  - Package clk_div_pkg: DIV_MIN=2; run-FSM state typedef {IDLE, RUN, STOP};
//    default CNT_W.
//  - Sub-module clk_div_negret: single negedge flop with async active-low reset
//    (d, q). Isolates the only negedge logic for STA/DFT.
// TESTING
//  1 Reset defaults: hold en=1 from reset release.
//    -> div_cur=7, clk_out period 7 clk, high 3.5 clk, div_err=0.
//  2 Even ratio: div_load with N=4.
//    -> change applies at the next wrap; period 4, high exactly 2 clk, no runt at switch.
//  3 Odd/even sweep: N=2,3,5,255.
//    -> high time N/2 clk and period N clk for each; N=3 high 1.5 clk.
//  4 Illegal load: div_load with N=1, then N=0.
//    -> div_err=1, div_cur unchanged, clk_out undisturbed.
//  5 Stop/start: drop en mid-high-phase at N=6.
//    -> the period completes, clk_out parks low.
//    Re-raise en -> clk_out rises 1 clk later.
//    Raising en during STOP -> no gap.
//  6 Async reset mid-period: rst_n low for 0.3 clk.
//    -> clk_out=0 immediately; after release, outputs match test 1.
//    With CLK_DIV_TICK_EN, tick count equals clk_out rising-edge count.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: run-control
// state encoding, minimum legal ratio and default counter width.
package clk_div_pkg;

    // Default width of the ratio register and period counter.
    localparam int CNT_W_DEF = 8;

    // Smallest ratio that still yields a 50% duty divided clock.
    localparam int DIV_MIN = 2;

    // Run-control states. IDLE holds the counter and clk_out low, RUN
    // free-runs, STOP finishes the current period before parking in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } run_state_e;

endpackage

// File: rtl/clk_div_negret.sv
// Half-cycle retiming flop clocked on the falling source edge. Kept in its
// own module so the only negedge-clocked logic of the divider is isolated.
module clk_div_negret (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Capture d on the falling edge; asynchronous active-low reset.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even
// ratios. A new ratio is staged in a pending slot and only takes over at the
// end of a period (or at once while stopped), so clk_out never produces a
// runt pulse. The run FSM lets the divided clock start and stop on period
// boundaries.
//
// Optional feature: define CLK_DIV_TICK_EN to add the clk_out_tick output, a
// one-cycle pulse on the source posedge where clk_out rises.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 7          // must be >= DIV_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk_out,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_err
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             clk_out_tick
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             odd_q, odd_d;
    logic             err_q, err_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;

    logic             running;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] half;

    // The counter runs in RUN and STOP; the wrap cycle is the last count of
    // a period. Pending ratios apply on a wrap, or immediately when parked.
    assign running = (state_q != IDLE);
    assign half    = div_cur_q >> 1;
    assign wrap    = running && (cnt_q == (div_cur_q - CNT_ONE));
    assign apply   = pend_vld_q && (wrap || !running);

    // Run control: stopping waits for the wrap so the last pulse is whole.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period counter plus the posedge half of the output waveform.
    always_comb begin
        cnt_d = '0;
        if (running) begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
        end
        pos_d = running && (cnt_q < half);
    end

    // Ratio staging: loads fill the pending slot (last wins), illegal
    // ratios only raise the sticky error, and the parity travels with
    // div_cur so the odd/even waveform switches on the same edge.
    always_comb begin
        div_cur_d  = div_cur_q;
        odd_d      = odd_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        if (apply) begin
            div_cur_d  = pend_q;
            odd_d      = pend_q[0];
            pend_vld_d = 1'b0;
        end
        if (div_load) begin
            if (div_ratio >= DIV_LO) begin
                pend_d     = div_ratio;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Posedge state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DIV_RST;
            odd_q      <= DIV_RST[0];
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            odd_q      <= odd_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    // The half-cycle extension only carries data for odd ratios. Masking it
    // for even ratios keeps neg_q low whenever the parity select changes, so
    // clk_out can be a plain OR without stretching the last even pulse.
    assign neg_d = pos_q & odd_q;

    clk_div_negret u_negret (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (neg_d),
        .q     (neg_q)
    );

    assign clk_out = pos_q | neg_q;
    assign div_cur = div_cur_q;
    assign div_err = err_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q, tick_d;

    // Tick fires on the same posedge that raises clk_out (count 0, running).
    always_comb begin
        tick_d = running && (cnt_q == '0);
    end

    // Registered tick with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign clk_out_tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog. Edge times of clk_out are logged by two
// monitors; each scenario task derives periods and high times from those
// logs and compares them against hand-computed values (10 ns source clock).
`timescale 1ns/1ps
module tb_clk_div_prog;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_ratio;
    logic             clk_out;
    logic [CNT_W-1:0] div_cur;
    logic             div_err;
`ifdef CLK_DIV_TICK_EN
    logic             clk_out_tick;
    int               tick_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int rise_t_q[$];
    int fall_t_q[$];

    clk_div_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .clk_out      (clk_out),
        .div_cur      (div_cur),
        .div_err      (div_err)
`ifdef CLK_DIV_TICK_EN
        ,
        .clk_out_tick (clk_out_tick)
`endif
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-time monitors for clk_out
    always @(posedge clk_out) rise_t_q.push_back($rtoi($realtime));
    always @(negedge clk_out) fall_t_q.push_back($rtoi($realtime));

`ifdef CLK_DIV_TICK_EN
    always @(negedge clk) if (clk_out_tick === 1'b1) tick_cnt++;
`endif

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int fall_after(input int t);
        for (int i = 0; i < fall_t_q.size(); i++) begin
            if (fall_t_q[i] > t) return fall_t_q[i];
        end
        return -1;
    endfunction

    function automatic int period_of(input int k);
        return rise_t_q[k+1] - rise_t_q[k];
    endfunction

    function automatic int high_of(input int k);
        return fall_after(rise_t_q[k]) - rise_t_q[k];
    endfunction

    // Driver tasks
    task automatic wait_rises(input int target, input int budget, output bit ok);
        int c = 0;
        while (rise_t_q.size() < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (rise_t_q.size() >= target);
    endtask

    task automatic wait_div(input logic [CNT_W-1:0] n, input int budget, output bit ok);
        int c = 0;
        while (div_cur !== n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (div_cur === n);
    endtask

    task automatic load_ratio(input logic [CNT_W-1:0] n);
        div_ratio = n;
        div_load  = 1'b1;
        @(negedge clk);
        div_load  = 1'b0;
    endtask

    // Test 1: reset defaults, divide-by-7 from reset release
    task automatic test_reset();
        int t_rel, ri0;
        bit ok;
        rst_n = 1'b0; en = 1'b1; div_load = 1'b0; div_ratio = '0;
        repeat (3) @(negedge clk);
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
        checks++; if (div_cur !== 8'd7) begin errors++; $display("FAIL reset_div_cur: got %0d expected 7", div_cur); end
        checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
`ifdef CLK_DIV_TICK_EN
        checks++; if (clk_out_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", clk_out_tick); end
`endif
        rst_n = 1'b1;
        t_rel = $rtoi($realtime);
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 4, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_timeout: got %0d rises expected %0d", rise_t_q.size() - ri0, 4); end
        if (ok) begin
            checks++; if (rise_t_q[ri0] !== t_rel + 15) begin errors++; $display("FAIL reset_first_rise: got %0d expected %0d", rise_t_q[ri0], t_rel + 15); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (period_of(ri0 + k) !== 70) begin errors++; $display("FAIL reset_period[%0d]: got %0d expected 70", k, period_of(ri0 + k)); end
                checks++; if (high_of(ri0 + k) !== 35) begin errors++; $display("FAIL reset_high[%0d]: got %0d expected 35", k, high_of(ri0 + k)); end
            end
        end
    endtask

    // Test 2: switch 7 -> 4 at the next wrap without a runt pulse
    task automatic test_even_ratio();
        int ri0;
        bit ok;
        int exp_per[3] = '{70, 40, 40};
        int exp_hi[3]  = '{35, 20, 20};
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 1, 20, ok);
        load_ratio(8'd4);
        checks++; if (div_cur !== 8'd7) begin errors++; $display("FAIL even_hold_div_cur: got %0d expected 7", div_cur); end
        wait_rises(ri0 + 4, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL even_timeout: got %0d rises expected 4", rise_t_q.size() - ri0); end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (period_of(ri0 + k) !== exp_per[k]) begin errors++; $display("FAIL even_period[%0d]: got %0d expected %0d", k, period_of(ri0 + k), exp_per[k]); end
                checks++; if (high_of(ri0 + k) !== exp_hi[k]) begin errors++; $display("FAIL even_high[%0d]: got %0d expected %0d", k, high_of(ri0 + k), exp_hi[k]); end
            end
        end
        checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL even_div_cur: got %0d expected 4", div_cur); end
    endtask

    // Test 3: odd/even sweep including the largest ratio
    task automatic test_sweep();
        int ns[4] = '{2, 3, 5, 255};
        int ri0;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            load_ratio(CNT_W'(ns[i]));
            wait_div(CNT_W'(ns[i]), 600, ok);
            checks++; if (!ok) begin errors++; $display("FAIL sweep_apply_n%0d: got %0d expected %0d", ns[i], div_cur, ns[i]); end
            ri0 = rise_t_q.size();
            wait_rises(ri0 + 3, 3 * ns[i] + 20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL sweep_timeout_n%0d: got %0d rises expected 3", ns[i], rise_t_q.size() - ri0); end
            if (ok) begin
                for (int k = 0; k < 2; k++) begin
                    checks++; if (period_of(ri0 + k) !== ns[i] * 10) begin errors++; $display("FAIL sweep_period_n%0d[%0d]: got %0d expected %0d", ns[i], k, period_of(ri0 + k), ns[i] * 10); end
                    checks++; if (high_of(ri0 + k) !== ns[i] * 5) begin errors++; $display("FAIL sweep_high_n%0d[%0d]: got %0d expected %0d", ns[i], k, high_of(ri0 + k), ns[i] * 5); end
                end
            end
        end
    endtask

    // Test 4: illegal loads set the sticky error and leave clk_out alone
    task automatic test_illegal_load();
        int ri0;
        bit ok;
        load_ratio(8'd5);
        wait_div(8'd5, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL illegal_setup: got %0d expected 5", div_cur); end
        checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL illegal_err_before: got %b expected 0", div_err); end
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 1, 20, ok);
        load_ratio(8'd1);
        checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL illegal_err_n1: got %b expected 1", div_err); end
        checks++; if (div_cur !== 8'd5) begin errors++; $display("FAIL illegal_div_cur_n1: got %0d expected 5", div_cur); end
        load_ratio(8'd0);
        checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL illegal_err_n0: got %b expected 1", div_err); end
        wait_rises(ri0 + 4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL illegal_timeout: got %0d rises expected 4", rise_t_q.size() - ri0); end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (period_of(ri0 + k) !== 50) begin errors++; $display("FAIL illegal_period[%0d]: got %0d expected 50", k, period_of(ri0 + k)); end
                checks++; if (high_of(ri0 + k) !== 25) begin errors++; $display("FAIL illegal_high[%0d]: got %0d expected 25", k, high_of(ri0 + k)); end
            end
        end
        checks++; if (div_cur !== 8'd5) begin errors++; $display("FAIL illegal_div_cur_end: got %0d expected 5", div_cur); end
    endtask

    // Test 5: stop mid-high at N=6, restart, and re-enable during STOP
    task automatic test_stop_start();
        int ri0, r1, t_en;
        bit ok;
        load_ratio(8'd6);
        wait_div(8'd6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_setup: got %0d expected 6", div_cur); end
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 1, 20, ok);
        en = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (high_of(ri0) !== 30) begin errors++; $display("FAIL stop_last_high: got %0d expected 30", high_of(ri0)); end
        checks++; if (rise_t_q.size() !== ri0 + 1) begin errors++; $display("FAIL stop_parked_rises: got %0d expected %0d", rise_t_q.size(), ri0 + 1); end
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL stop_parked_low: got %b expected 0", clk_out); end
        en = 1'b1;
        t_en = $rtoi($realtime);
        wait_rises(ri0 + 2, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: got %0d rises expected 1", rise_t_q.size() - ri0 - 1); end
        if (ok) begin
            checks++; if (rise_t_q[ri0 + 1] !== t_en + 15) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", rise_t_q[ri0 + 1], t_en + 15); end
        end
        r1 = rise_t_q.size();
        wait_rises(r1 + 1, 20, ok);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_rises(r1 + 4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL resume_timeout: got %0d rises expected 4", rise_t_q.size() - r1); end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (period_of(r1 + k) !== 60) begin errors++; $display("FAIL resume_period[%0d]: got %0d expected 60", k, period_of(r1 + k)); end
                checks++; if (high_of(r1 + k) !== 30) begin errors++; $display("FAIL resume_high[%0d]: got %0d expected 30", k, high_of(r1 + k)); end
            end
        end
    endtask

    // Test 6: asynchronous reset pulse in the middle of a high phase
    task automatic test_async_reset();
        int ri0, t_rel;
        bit ok;
`ifdef CLK_DIV_TICK_EN
        int tick_base;
`endif
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 1, 20, ok);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL areset_clk_out: got %b expected 0", clk_out); end
        checks++; if (div_cur !== 8'd7) begin errors++; $display("FAIL areset_div_cur: got %0d expected 7", div_cur); end
        checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL areset_div_err: got %b expected 0", div_err); end
        #2 rst_n = 1'b1;
        t_rel = $rtoi($realtime);
`ifdef CLK_DIV_TICK_EN
        tick_base = tick_cnt;
`endif
        ri0 = rise_t_q.size();
        wait_rises(ri0 + 3, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_timeout: got %0d rises expected 3", rise_t_q.size() - ri0); end
        if (ok) begin
            checks++; if (rise_t_q[ri0] !== t_rel + 11) begin errors++; $display("FAIL areset_first_rise: got %0d expected %0d", rise_t_q[ri0], t_rel + 11); end
            for (int k = 0; k < 2; k++) begin
                checks++; if (period_of(ri0 + k) !== 70) begin errors++; $display("FAIL areset_period[%0d]: got %0d expected 70", k, period_of(ri0 + k)); end
                checks++; if (high_of(ri0 + k) !== 35) begin errors++; $display("FAIL areset_high[%0d]: got %0d expected 35", k, high_of(ri0 + k)); end
            end
        end
`ifdef CLK_DIV_TICK_EN
        #1;
        checks++; if (tick_cnt - tick_base !== rise_t_q.size() - ri0) begin errors++; $display("FAIL areset_tick_count: got %0d expected %0d", tick_cnt - tick_base, rise_t_q.size() - ri0); end
`endif
    endtask

    // Scenario sequence and final report
    initial begin
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_ratio = '0;
        @(negedge clk);
        test_reset();
        test_even_ratio();
        test_sweep();
        test_illegal_load();
        test_stop_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
